// File: rtl/mac_acc_pipe.sv
// Convolution MAC: KxK products, tree sum, per-channel accumulate, shift/clamp/ReLU output.
// Latency 3 edges from the last-beat accept to out_valid; a held output freezes the whole pipe and drops in_ready.
module mac_acc_pipe #(
    parameter int DATA_WIDTH   = 8,
    parameter int KERNEL_SIZE  = 3,
    parameter int NUM_CHANNELS = 4,
    parameter int ACC_WIDTH    = 32,
    parameter int OUT_WIDTH    = 16,
    parameter int SHIFT        = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]        feature [KERNEL_SIZE][KERNEL_SIZE],
    input  logic signed [DATA_WIDTH-1:0] kernel  [KERNEL_SIZE][KERNEL_SIZE],
    input  logic signed [ACC_WIDTH-1:0]  bias,
    input  logic                        relu_en,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                        busy
);

    localparam int KK = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PW = 2 * DATA_WIDTH + 1;
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_CHANNELS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic                 stall, adv, accept;
    logic                 beat_first, beat_last, beat_relu;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 grp_relu_q;

    logic                 s1_vld_q, s1_first_q, s1_last_q, s1_relu_q;
    logic signed [ACC_WIDTH-1:0] s1_bias_q;
    logic signed [PW-1:0] s1_prod_q [KK];
    logic signed [PW-1:0] prod_d    [KK];

    logic                 s2_vld_q, s2_first_q, s2_last_q, s2_relu_q;
    logic signed [ACC_WIDTH-1:0] s2_bias_q, s2_sum_q, sum_d;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, shifted, clamp_lo, clamped;
    logic                 s3_fin_q, s3_relu_q, part_q;

    logic                 out_valid_q;
    logic signed [OUT_WIDTH-1:0] out_data_q;

    always_comb begin
        stall      = out_valid_q & ~out_ready;
        adv        = ~stall;
        in_ready   = adv;
        accept     = in_valid & adv;
        beat_first = (cnt_q == '0);
        beat_last  = (cnt_q == CNT_LAST);
        // relu_en is only sampled on channel 0; later beats inherit the group value
        beat_relu  = beat_first ? relu_en : grp_relu_q;
        cnt_d      = beat_last ? '0 : cnt_q + CW'(1);
    end

    always_comb begin
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            for (int j = 0; j < KERNEL_SIZE; j++) begin
                prod_d[i*KERNEL_SIZE+j] =
                    $signed({{(DATA_WIDTH+1){1'b0}}, feature[i][j]}) *
                    $signed({{(DATA_WIDTH+1){kernel[i][j][DATA_WIDTH-1]}}, kernel[i][j]});
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int p = 0; p < KK; p++) begin
            sum_d = sum_d + {{(ACC_WIDTH-PW){s1_prod_q[p][PW-1]}}, s1_prod_q[p]};
        end
    end

    always_comb begin
        acc_d   = (s2_first_q ? s2_bias_q : acc_q) + s2_sum_q;
        shifted = acc_q >>> SHIFT;
        if (s3_relu_q) clamp_lo = '0;
        else           clamp_lo = SAT_LO;
        if (shifted > SAT_HI)        clamped = SAT_HI;
        else if (shifted < clamp_lo) clamped = clamp_lo;
        else                         clamped = shifted;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            grp_relu_q  <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_relu_q   <= 1'b0;
            s1_bias_q   <= '0;
            for (int p = 0; p < KK; p++) s1_prod_q[p] <= '0;
            s2_vld_q    <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_relu_q   <= 1'b0;
            s2_bias_q   <= '0;
            s2_sum_q    <= '0;
            acc_q       <= '0;
            s3_fin_q    <= 1'b0;
            s3_relu_q   <= 1'b0;
            part_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (adv) begin
            if (accept) begin
                cnt_q <= cnt_d;
                if (beat_first) grp_relu_q <= relu_en;
            end
            s1_vld_q   <= accept;
            s1_first_q <= beat_first;
            s1_last_q  <= beat_last;
            s1_relu_q  <= beat_relu;
            s1_bias_q  <= bias;
            s1_prod_q  <= prod_d;

            s2_vld_q   <= s1_vld_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            s2_relu_q  <= s1_relu_q;
            s2_bias_q  <= s1_bias_q;
            s2_sum_q   <= sum_d;

            if (s2_vld_q) begin
                acc_q     <= acc_d;
                s3_relu_q <= s2_relu_q;
                part_q    <= ~s2_last_q;
            end
            s3_fin_q <= s2_vld_q & s2_last_q;

            // acc_q may be reloaded by the next group on this same edge; the output takes the old value
            out_valid_q <= s3_fin_q;
            if (s3_fin_q) out_data_q <= clamped[OUT_WIDTH-1:0];
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = s1_vld_q | s2_vld_q | s3_fin_q | part_q | out_valid_q | (cnt_q != '0);

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Directed bench for mac_acc_pipe: default, SHIFT=4 and single-channel instances share stimulus.
module tb_mac_acc_pipe;

    logic               clk = 1'b0;
    logic               reset;
    logic [7:0]         feature [3][3];
    logic signed [7:0]  kernel  [3][3];
    logic signed [31:0] bias;
    logic               relu_en, in_valid, out_ready;

    logic               a_in_ready, a_out_valid, a_busy;
    logic               b_in_ready, b_out_valid, b_busy;
    logic               c_in_ready, c_out_valid, c_busy;
    logic signed [15:0] a_out_data, b_out_data, c_out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_acc_pipe u_a (
        .clk(clk), .reset(reset), .feature(feature), .kernel(kernel), .bias(bias),
        .relu_en(relu_en), .in_valid(in_valid), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .busy(a_busy)
    );

    mac_acc_pipe #(.SHIFT(4)) u_b (
        .clk(clk), .reset(reset), .feature(feature), .kernel(kernel), .bias(bias),
        .relu_en(relu_en), .in_valid(in_valid), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .busy(b_busy)
    );

    mac_acc_pipe #(.NUM_CHANNELS(1)) u_c (
        .clk(clk), .reset(reset), .feature(feature), .kernel(kernel), .bias(bias),
        .relu_en(relu_en), .in_valid(in_valid), .in_ready(c_in_ready),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data), .busy(c_busy)
    );

    task automatic set_window(input logic [7:0] f, input logic signed [7:0] k);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                feature[i][j] = f;
                kernel[i][j]  = k;
            end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; bias = '0; relu_en = 1'b0;
        set_window(8'd0, 8'sd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Four beats of the current window; bias/relu_en only valid on beat 0, the rest carry junk.
    task automatic run_group(input logic signed [31:0] b0, input logic r0,
                             output logic signed [15:0] da, output logic signed [15:0] db,
                             output int lat);
        bias = b0; relu_en = r0; in_valid = 1'b1;
        @(posedge clk); #1;
        bias = 32'sd1000; relu_en = ~r0;
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        da = a_out_data; db = b_out_data;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b%b%b exp=000", a_out_valid, b_out_valid, c_out_valid); end
        checks++; if (a_out_data !== 16'sd0 || b_out_data !== 16'sd0 || c_out_data !== 16'sd0) begin
            failures++; $display("FAIL reset_out_data got=%0d,%0d,%0d exp=0", a_out_data, b_out_data, c_out_data); end
        checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0 || c_busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b%b%b exp=000", a_busy, b_busy, c_busy); end
        checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b%b%b exp=111", a_in_ready, b_in_ready, c_in_ready); end
    endtask

    task automatic test_basic();
        logic signed [15:0] da, db;
        int lat;
        do_reset();
        set_window(8'd1, 8'sd1);
        run_group(32'sd0, 1'b0, da, db, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        checks++; if (da !== 16'sd36) begin failures++; $display("FAIL basic_data got=%0d exp=36", da); end
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", a_out_valid); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_idle got=%b exp=0", a_busy); end
    endtask

    task automatic test_saturate();
        logic signed [15:0] da, db;
        int lat;
        do_reset();
        set_window(8'd255, -8'sd128);
        run_group(32'sd0, 1'b0, da, db, lat);
        checks++; if (da !== 16'h8000) begin failures++; $display("FAIL sat_neg got=%0d exp=-32768", da); end
        run_group(32'sd0, 1'b1, da, db, lat);
        checks++; if (da !== 16'sd0) begin failures++; $display("FAIL sat_relu got=%0d exp=0", da); end
        set_window(8'd255, 8'sd127);
        run_group(32'sd0, 1'b0, da, db, lat);
        checks++; if (da !== 16'sd32767) begin failures++; $display("FAIL sat_pos got=%0d exp=32767", da); end
    endtask

    task automatic test_shift();
        logic signed [15:0] da, db;
        int lat;
        do_reset();
        set_window(8'd2, 8'sd3);
        run_group(-32'sd6, 1'b0, da, db, lat);
        checks++; if (da !== 16'sd210) begin failures++; $display("FAIL shift_noshift got=%0d exp=210", da); end
        checks++; if (db !== 16'sd13) begin failures++; $display("FAIL shift_by4 got=%0d exp=13", db); end
    endtask

    task automatic test_window();
        logic signed [15:0] da, db;
        int lat;
        do_reset();
        // features 1..9 in raster order, kernel alternating 3 / -2: 75 - 40 = 35 per beat
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                feature[i][j] = 8'(i*3 + j + 1);
                kernel[i][j]  = ((i*3 + j) % 2 == 1) ? -8'sd2 : 8'sd3;
            end
        run_group(32'sd0, 1'b0, da, db, lat);
        checks++; if (da !== 16'sd140) begin failures++; $display("FAIL window_sum got=%0d exp=140", da); end
        checks++; if (db !== 16'sd8) begin failures++; $display("FAIL window_shift got=%0d exp=8", db); end
    endtask

    task automatic test_stall();
        int sent = 0, stall_cyc = 0, nres = 0;
        logic seen_low = 1'b0, stable_ok = 1'b1, will_acc;
        logic signed [15:0] held = '0;
        logic signed [15:0] res [2];
        res[0] = '0; res[1] = '0;
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; set_window(8'd1, 8'sd1);
        for (int cyc = 0; cyc < 60 && nres < 2; cyc++) begin
            will_acc = in_valid && a_in_ready;
            @(posedge clk); #1;
            if (will_acc) begin
                sent++;
                if (sent >= 8) in_valid = 1'b0;
                else set_window((sent < 4) ? 8'd1 : 8'(sent - 3), 8'sd1);
            end
            if (a_out_valid && !out_ready) begin
                if (!a_in_ready) seen_low = 1'b1;
                if (stall_cyc == 0) held = a_out_data;
                else if (a_out_data !== held) stable_ok = 1'b0;
                stall_cyc++;
                if (stall_cyc == 5) out_ready = 1'b1;
            end
            if (a_out_valid && out_ready) begin res[nres] = a_out_data; nres++; end
        end
        checks++; if (nres !== 2) begin failures++; $display("FAIL stall_results got=%0d exp=2", nres); end
        checks++; if (sent !== 8) begin failures++; $display("FAIL stall_accepts got=%0d exp=8", sent); end
        checks++; if (seen_low !== 1'b1) begin failures++; $display("FAIL stall_in_ready_drop got=%b exp=1", seen_low); end
        checks++; if (stable_ok !== 1'b1) begin failures++; $display("FAIL stall_hold got=%b exp=1", stable_ok); end
        checks++; if (res[0] !== 16'sd36) begin failures++; $display("FAIL stall_res0 got=%0d exp=36", res[0]); end
        checks++; if (res[1] !== 16'sd90) begin failures++; $display("FAIL stall_res1 got=%0d exp=90", res[1]); end
    endtask

    task automatic test_reset_mid();
        logic signed [15:0] da, db;
        int lat;
        do_reset();
        set_window(8'd200, 8'sd50);
        bias = 32'sd77; in_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", a_busy); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%b exp=1", a_in_ready); end
        set_window(8'd1, 8'sd1);
        run_group(32'sd0, 1'b0, da, db, lat);
        checks++; if (da !== 16'sd36) begin failures++; $display("FAIL midreset_data got=%0d exp=36", da); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL midreset_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_back_to_back();
        logic exp_a_vld, exp_c_vld;
        logic signed [15:0] exp_a, exp_c;
        do_reset();
        bias = 32'sd5; in_valid = 1'b1; set_window(8'd1, 8'sd1);
        for (int e = 0; e < 14; e++) begin
            @(posedge clk); #1;
            if (e < 7) set_window(8'(e + 2), 8'sd1);
            else in_valid = 1'b0;
            exp_c_vld = (e >= 3 && e <= 10);
            exp_c     = 16'(9 * (e - 2) + 5);
            exp_a_vld = (e == 6 || e == 10);
            exp_a     = (e == 6) ? 16'sd95 : 16'sd239;
            checks++; if (c_in_ready !== 1'b1) begin failures++; $display("FAIL b2b_c_in_ready e=%0d got=%b exp=1", e, c_in_ready); end
            checks++; if (c_out_valid !== exp_c_vld) begin failures++; $display("FAIL b2b_c_valid e=%0d got=%b exp=%b", e, c_out_valid, exp_c_vld); end
            if (exp_c_vld) begin
                checks++; if (c_out_data !== exp_c) begin failures++; $display("FAIL b2b_c_data e=%0d got=%0d exp=%0d", e, c_out_data, exp_c); end
            end
            checks++; if (a_out_valid !== exp_a_vld) begin failures++; $display("FAIL b2b_a_valid e=%0d got=%b exp=%b", e, a_out_valid, exp_a_vld); end
            if (exp_a_vld) begin
                checks++; if (a_out_data !== exp_a) begin failures++; $display("FAIL b2b_a_data e=%0d got=%0d exp=%0d", e, a_out_data, exp_a); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_shift();
        test_window();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac_acc_pipe.md
MAC_ACC_PIPE -- requirements
Module: mac_acc_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the feature/kernel element width.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3, the window side length (KERNEL_SIZE x KERNEL_SIZE products per beat).
REQ-003 SHALL have parameter NUM_CHANNELS, default 4, the input-channel beats accumulated per output (>=1).
REQ-004 SHALL have parameters ACC_WIDTH, default 32, the signed accumulator width; OUT_WIDTH, default 16, the signed output width; SHIFT, default 0, the arithmetic right shift applied before clamping.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port feature, input, unsigned [DATA_WIDTH-1:0] [KERNEL_SIZE][KERNEL_SIZE], the feature window.
REQ-008 SHALL have port kernel, input, signed [DATA_WIDTH-1:0] [KERNEL_SIZE][KERNEL_SIZE], the weights.
REQ-009 SHALL have port bias, input, signed [ACC_WIDTH-1:0], sampled only with a channel-0 beat.
REQ-010 SHALL have port relu_en, input, 1, sampled only with a channel-0 beat; it sets the lower clamp bound to 0.
REQ-011 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the input handshake.
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, signed [OUT_WIDTH-1:0]), the output handshake.
REQ-013 SHALL have port busy, output, 1, high while any pipeline stage or a partial accumulation holds data.

Function
REQ-014 SHALL accept a beat on a rising edge with in_valid=1 and in_ready=1; in_valid/in_ready SHALL have no other effect.
REQ-015 SHALL set stall = out_valid & ~out_ready; in_ready = ~stall; stall SHALL freeze every pipeline register, the counter and the accumulator.
REQ-016 Stage 1 SHALL register the KERNEL_SIZE^2 products; each product SHALL be the zero-extended feature times the signed kernel, width 2*DATA_WIDTH+1, exact.
REQ-017 Stage 2 SHALL register the sign-extended sum of all products at ACC_WIDTH bits, with wrap on overflow.
REQ-018 Stage 3 SHALL update the accumulator: acc = bias + sum on a channel-0 beat, and acc = acc + sum on other beats, at ACC_WIDTH bits with wrap.
REQ-019 SHALL keep a channel counter of accepted beats in the range 0..NUM_CHANNELS-1; it SHALL wrap to 0 after NUM_CHANNELS-1, and the tag (first, last) SHALL travel with each beat through the stages.
REQ-020 When the last-tagged beat reaches stage 3, the block SHALL set out_valid=1 and out_data=clamp(acc_final >>> SHIFT, lo, 2^(OUT_WIDTH-1)-1); lo SHALL be 0 if relu_en, else -2^(OUT_WIDTH-1).
REQ-021 Latency SHALL be 3 cycles: with no stall, out_valid is high in the cycle after the third rising edge following acceptance of the last beat.
REQ-022 out_valid and out_data SHALL hold stable until out_valid & out_ready; if no new result is produced on that edge, out_valid SHALL drop.
REQ-023 Back-to-back outputs SHALL be supported: with out_ready held high, one result SHALL be produced every NUM_CHANNELS accepted beats, with no bubbles.
REQ-024 When NUM_CHANNELS=1, each beat SHALL be tagged both first and last, giving acc = bias + sum.
REQ-025 A channel-0 beat SHALL be able to enter stage 3 on the same edge the previous result is consumed, with no conflict.

Reset
REQ-026 While reset is high at a rising edge, the block SHALL clear all stage valids, set the channel counter to 0, set acc=0, out_valid=0, out_data=0 and busy=0.
REQ-027 in_ready SHALL equal 1 in the cycle after reset.
REQ-028 Reset mid-accumulation SHALL discard the partial sum, and the next accepted beat SHALL be treated as channel 0.
REQ-029 Reset SHALL have priority over every handshake on the same edge.

Verification
REQ-030 Defaults: all feature=1, all kernel=1, bias=0, relu_en=0, 4 beats streamed, out_ready=1 -> single out_data=36, out_valid exactly 3 cycles after the 4th accept.
REQ-031 feature=255, kernel=-128 (all elements), 4 beats, bias=0, relu_en=0 -> acc=-1175040, out_data=-32768 (saturated); the same input with relu_en=1 -> out_data=0.
REQ-032 SHIFT=4, feature=2, kernel=3, bias=-6, 4 beats -> acc=210, out_data=13.
REQ-033 out_ready=0 for 5 cycles while 8 beats are offered -> in_ready drops, out_data holds stable, no beat is lost, and both results are correct once out_ready=1.
REQ-034 reset asserted after 2 of 4 beats, then 4 fresh beats of ones -> out_data=36, and the pre-reset data has no effect.
REQ-035 NUM_CHANNELS=1 with continuous beats and out_ready=1 -> one result per cycle after a 3-cycle fill, and in_ready held at 1.
